// File: rtl/adc_seq_pkg.sv
// Shared encodings for the Intan ADC sequencer: FSM states, stage codes and
// cache_cmd field positions.
package adc_seq_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT      = 3'd1;
  localparam logic [2:0] S_TYPE      = 3'd2;
  localparam logic [2:0] S_CONF      = 3'd3;
  localparam logic [2:0] S_CONV_WAIT = 3'd4;
  localparam logic [2:0] S_CONV      = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  localparam logic [1:0] STG_INIT = 2'd0;
  localparam logic [1:0] STG_TYPE = 2'd1;
  localparam logic [1:0] STG_CONF = 2'd2;
  localparam logic [1:0] STG_CONV = 2'd3;

  localparam int CMD_FS_MSB  = 23;
  localparam int CMD_FS_LSB  = 20;
  localparam int CMD_FU_MSB  = 19;
  localparam int CMD_FU_LSB  = 16;
  localparam int CMD_FL_MSB  = 15;
  localparam int CMD_FL_LSB  = 12;
  localparam int CFG_MSB     = CMD_FS_MSB;
  localparam int CFG_LSB     = CMD_FL_LSB;

  function automatic logic [1:0] stage_of(input logic [2:0] s);
    case (s)
      S_TYPE:  return STG_TYPE;
      S_CONF:  return STG_CONF;
      S_CONV:  return STG_CONV;
      default: return STG_INIT;
    endcase
  endfunction

endpackage

// File: rtl/adc_seq_hs.sv
// Generic fs/fd handshake watcher shared by all handshake states.
// Wait counter and timeout exist only when ADC_SEQ_TIMEOUT_EN is defined.
module adc_seq_hs
  import adc_seq_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic active,
  input  logic fd,
  output logic done,
  output logic tmo
);

  assign done = active & fd;

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      wait_cnt <= '0;
    else if (active && !fd)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // fires on the cycle the count would reach TIMEOUT, so fs stays up TIMEOUT cycles
  assign tmo = active & ~fd & (wait_cnt == TW'(TIMEOUT - 1));
`else
  logic unused_hs;
  assign unused_hs = ^{clk, rst, clr, (TIMEOUT != 0)};
  assign tmo = 1'b0;
`endif

endmodule

// File: rtl/adc_seq_ctrl.sv
// Sequencer for the four-channel Intan ADC: init/type/conf handshakes then a
// periodic conv loop. ADC_SEQ_TIMEOUT_EN enables handshake timeout and ERR.
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int PERIOD_UNIT = 2500,
  parameter int TIMEOUT     = 65535,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      cache_cmd,
  output logic             fs_init,
  output logic             fs_type,
  output logic             fs_conf,
  output logic             fs_conv,
  input  logic             fd_init,
  input  logic             fd_type,
  input  logic             fd_conf,
  input  logic             fd_conv,
  output logic             ready,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_stage,
  output logic [CNT_W-1:0] conv_cnt,
  output logic [CNT_W-1:0] ovr_cnt
);

  localparam int CW = CFG_MSB - CFG_LSB + 1;

  logic [2:0]    state, nxt;
  logic          stop_pend, stp;
  logic [CW-1:0] cfg, cmd_cfg;
  logic [31:0]   pcnt, period;
  logic          tick, cfg_chg;
  logic          hs_act, hs_fd, hs_done, hs_tmo;

  assign cmd_cfg = cache_cmd[CFG_MSB:CFG_LSB];
  assign cfg_chg = (cmd_cfg != cfg);
  assign stp     = stop | stop_pend;
  assign ready   = (state == S_CONV_WAIT) || (state == S_CONV);
  assign busy    = (state != S_IDLE) && (state != S_ERR);

  assign period = (32'(cfg[CMD_FS_MSB-CFG_LSB:CMD_FS_LSB-CFG_LSB]) + 32'd1) * 32'(PERIOD_UNIT);
  assign tick   = ready && (pcnt == period - 32'd1);

  assign hs_act = (state == S_INIT) || (state == S_TYPE) || (state == S_CONF) || (state == S_CONV);

  always_comb begin
    hs_fd = 1'b0;
    case (state)
      S_INIT:  hs_fd = fd_init;
      S_TYPE:  hs_fd = fd_type;
      S_CONF:  hs_fd = fd_conf;
      S_CONV:  hs_fd = fd_conv;
      default: hs_fd = 1'b0;
    endcase
  end

  adc_seq_hs #(.TIMEOUT(TIMEOUT)) u_hs (
    .clk    (clk),
    .rst    (rst),
    .clr    (nxt != state),
    .active (hs_act),
    .fd     (hs_fd),
    .done   (hs_done),
    .tmo    (hs_tmo)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:      if (start) nxt = S_INIT;
      S_INIT:      if (hs_tmo) nxt = S_ERR; else if (hs_done) nxt = stp ? S_IDLE : S_TYPE;
      S_TYPE:      if (hs_tmo) nxt = S_ERR; else if (hs_done) nxt = stp ? S_IDLE : S_CONF;
      S_CONF:      if (hs_tmo) nxt = S_ERR; else if (hs_done) nxt = stp ? S_IDLE : S_CONV_WAIT;
      // a pending reconfig outranks a same-cycle tick
      S_CONV_WAIT: if (stp) nxt = S_IDLE; else if (cfg_chg) nxt = S_CONF; else if (tick) nxt = S_CONV;
      S_CONV:      if (hs_tmo) nxt = S_ERR; else if (hs_done) nxt = stp ? S_IDLE : S_CONV_WAIT;
      S_ERR:       if (start) nxt = S_INIT;
      default:     nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fs_init   <= 1'b0;
      fs_type   <= 1'b0;
      fs_conf   <= 1'b0;
      fs_conv   <= 1'b0;
      stop_pend <= 1'b0;
      cfg       <= '0;
      pcnt      <= '0;
      conv_cnt  <= '0;
      ovr_cnt   <= '0;
    end else begin
      state   <= nxt;
      fs_init <= (nxt == S_INIT);
      fs_type <= (nxt == S_TYPE);
      fs_conf <= (nxt == S_CONF);
      fs_conv <= (nxt == S_CONV);
      if (state == S_IDLE || state == S_ERR || nxt == S_IDLE || nxt == S_ERR)
        stop_pend <= 1'b0;
      else if (stop)
        stop_pend <= 1'b1;
      if (state == S_CONF && hs_done)
        cfg <= cmd_cfg;
      if (state == S_CONF && nxt == S_CONV_WAIT)
        pcnt <= '0;
      else if (ready)
        pcnt <= tick ? 32'd0 : pcnt + 32'd1;
      if (state == S_CONV && hs_done)
        conv_cnt <= conv_cnt + 1'b1;
      if (state == S_CONV && tick && ovr_cnt != '1)
        ovr_cnt <= ovr_cnt + 1'b1;
    end
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      err_stage <= STG_INIT;
    end else if (hs_tmo) begin
      err       <= 1'b1;
      err_stage <= stage_of(state);
    end else if (state == S_ERR && start) begin
      err       <= 1'b0;
      err_stage <= STG_INIT;
    end
  end
`else
  assign err       = 1'b0;
  assign err_stage = STG_INIT;
`endif

  logic unused_cmd;
  assign unused_cmd = ^{cache_cmd[31:CFG_MSB+1], cache_cmd[CFG_LSB-1:0]};

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed bench for adc_seq_ctrl with an fd responder (per-channel delay)
// and a strobe monitor; timeout checks depend on ADC_SEQ_TIMEOUT_EN.
module tb_adc_seq_ctrl;

  localparam int NEVER = 1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cache_cmd = 32'h0013_0000;
  logic [3:0]  fd = 4'b0;
  logic        fs_init, fs_type, fs_conf, fs_conv;
  logic        ready, busy, err;
  logic [1:0]  err_stage;
  logic [15:0] conv_cnt, ovr_cnt;

  always #5 clk = ~clk;

  adc_seq_ctrl #(.PERIOD_UNIT(10), .TIMEOUT(100), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cache_cmd(cache_cmd),
    .fs_init(fs_init), .fs_type(fs_type), .fs_conf(fs_conf), .fs_conv(fs_conv),
    .fd_init(fd[0]), .fd_type(fd[1]), .fd_conf(fd[2]), .fd_conv(fd[3]),
    .ready(ready), .busy(busy), .err(err), .err_stage(err_stage),
    .conv_cnt(conv_cnt), .ovr_cnt(ovr_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // responder + monitor share one process so there is no ordering race
  int dly[4] = '{3, 3, 3, 2};
  int age[4] = '{0, 0, 0, 0};
  int cyc = 0, run[4], len[4], rise[4], nrise[4], prev_rise_conv = 0;
  int multi_hi = 0, fdconf_cyc = 0, ready_rise = 0, n_ready_rise = 0;
  logic [3:0] fsv, fs_prev = 4'b0;
  logic ready_prev = 1'b0;

  assign fsv = {fs_conv, fs_conf, fs_type, fs_init};

  initial begin
    for (int i = 0; i < 4; i++) begin run[i] = 0; len[i] = 0; rise[i] = 0; nrise[i] = 0; end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        age[i] = fsv[i] ? age[i] + 1 : 0;
        fd[i]  = fsv[i] && (age[i] > dly[i]);
      end
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (fsv[i]) begin
          run[i]++;
          if (!fs_prev[i]) begin
            if (i == 3) prev_rise_conv = rise[3];
            rise[i] = cyc;
            nrise[i]++;
          end
        end else if (fs_prev[i]) begin
          len[i] = run[i];
          run[i] = 0;
        end
      end
      if ($countones(fsv) > 1) multi_hi++;
      if (fs_conf && fd[2]) fdconf_cyc = cyc;
      if (ready && !ready_prev) begin ready_rise = cyc; n_ready_rise++; end
      fs_prev    = fsv;
      ready_prev = ready;
    end
  end

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  int r1, nc, nr;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_fs", {28'd0, fsv}, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err_stage, err}, 0);
    chk("rst_cnt", {conv_cnt, ovr_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // bring-up: each fd 3 cycles after its fs
    pulse_start();
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    chk("bringup_ready", ready, 1);
    chk("len_init", len[0], 4);
    chk("len_type", len[1], 4);
    chk("len_conf", len[2], 4);
    chk("order_type", rise[1] - rise[0], 4);
    chk("order_conf", rise[2] - rise[1], 4);
    chk("ready_lat", ready_rise - fdconf_cyc, 1);

    // period 20 with PERIOD_UNIT=10, freq_samp=1
    for (int i = 0; i < 400 && conv_cnt != 5; i++) @(negedge clk);
    chk("conv_cnt5", conv_cnt, 5);
    chk("conv_period", rise[3] - prev_rise_conv, 20);
    chk("ovr_none", ovr_cnt, 0);

    // overrun: fd_conv held off 25 cycles
    dly[3] = 25;
    for (int i = 0; i < 200 && conv_cnt != 6; i++) @(negedge clk);
    chk("ovr_one", ovr_cnt, 1);
    chk("len_conv_long", len[3], 26);
    r1 = rise[3];
    dly[3] = 2;
    for (int i = 0; i < 200 && conv_cnt != 7; i++) @(negedge clk);
    chk("ovr_gap", rise[3] - r1, 40);
    chk("ovr_hold", ovr_cnt, 1);

    // filt_up 3 -> 5 while waiting: next strobe must be conf
    cache_cmd = 32'h0015_0000;
    for (int i = 0; i < 50 && !(fs_conf || fs_conv); i++) @(negedge clk);
    chk("reconf_conf", fs_conf, 1);
    chk("reconf_noconv", fs_conv, 0);
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    chk("reconf_ready", ready, 1);
    nc = nrise[2];
    for (int i = 0; i < 200 && conv_cnt != 9; i++) @(negedge clk);
    chk("reconf_cnt", conv_cnt, 9);
    chk("reconf_once", nrise[2] - nc, 0);
    chk("reconf_period", rise[3] - prev_rise_conv, 20);

    // stop while waiting for a tick
    pulse_stop();
    chk("stopw_busy", busy, 0);
    chk("stopw_ready", ready, 0);

    // stop during CONF, fd_conf after 5 cycles
    dly[2] = 5;
    nr = n_ready_rise;
    pulse_start();
    for (int i = 0; i < 50 && !fs_conf; i++) @(negedge clk);
    pulse_stop();
    for (int i = 0; i < 50 && fs_conf; i++) @(negedge clk);
    chk("stopc_len", len[2], 6);
    chk("stopc_busy", busy, 0);
    repeat (30) @(negedge clk);
    chk("stopc_noready", n_ready_rise - nr, 0);
    chk("stopc_cnt", conv_cnt, 9);
    chk("stopc_idle", {busy, fs_init}, 0);

    // start+stop together in IDLE: start wins
    dly[2] = 3;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_init", fs_init, 1);
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    chk("ss_ready", ready, 1);
    pulse_start();
    chk("busy_start_ign", {ready, fs_init}, 2'b10);
    pulse_stop();
    chk("ss_stop", busy, 0);

    dly[1] = NEVER;
    pulse_start();
    for (int i = 0; i < 50 && !fs_type; i++) @(negedge clk);
    chk("to_type_up", fs_type, 1);
`ifdef ADC_SEQ_TIMEOUT_EN
    for (int i = 0; i < 300 && fs_type; i++) @(negedge clk);
    chk("to_len", len[1], 100);
    chk("to_fs", fs_type, 0);
    chk("to_err", err, 1);
    chk("to_stage", err_stage, 1);
    chk("to_busy", busy, 0);
    dly[1] = 3;
    pulse_start();
    chk("to_clr", {err_stage, err}, 0);
    chk("to_restart", fs_init, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_fs", {28'd0, fsv}, 0);
`else
    repeat (150) @(negedge clk);
    chk("noto_fs", fs_type, 1);
    chk("noto_err", {err_stage, err}, 0);
    chk("noto_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_fs", {28'd0, fsv}, 0);
`endif
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cnt", {conv_cnt, ovr_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("onehot", multi_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
